// File: rtl/csc_rgb_pack_if.sv
// csc_rgb_pack_if: operand-in / RGB-word-out handshake bundle for csc_rgb_pack
interface csc_rgb_pack_if;
   logic               in_valid;
   logic               in_ready;
   logic [15:0]        y_word;
   logic signed [31:0] u_even;
   logic signed [31:0] v_even;
   logic signed [31:0] u_odd;
   logic signed [31:0] v_odd;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        out_data;
   logic               frame_done;
   logic [15:0]        clip_count;

   modport master (
      output in_valid, y_word, u_even, v_even, u_odd, v_odd, out_ready,
      input  in_ready, out_valid, out_data, frame_done, clip_count
   );

   modport slave (
      input  in_valid, y_word, u_even, v_even, u_odd, v_odd, out_ready,
      output in_ready, out_valid, out_data, frame_done, clip_count
   );
endinterface

// File: rtl/csc_rgb_pack.sv
// csc_rgb_pack: YUV pixel pair -> three packed RGB words using two shared multipliers; define CSC_CLIP_CNT_EN for the clip counter
module csc_rgb_pack #(
   parameter int PAIRS_PER_FRAME = 38400
) (
   input logic           CLOCK_50_I,
   input logic           resetn,
   csc_rgb_pack_if.slave bus
);
   typedef enum logic [3:0] {IDLE, C0, C1, C2, C3, C4, OUT0, OUT1, OUT2} state_t;

   localparam logic [15:0] LAST_PAIR = 16'(PAIRS_PER_FRAME - 1);

   state_t             state_q, state_d;
   logic [7:0]         y0_q, y1_q, u0_q, v0_q, u1_q, v1_q;
   logic signed [31:0] r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
   logic signed [31:0] coef, op0, op1, m0, m1, hi_acc, lo_acc;
   logic [15:0]        pair_q;
   logic               accept, take, last_taken, frame_end;

   function automatic logic [7:0] clamp8(input logic signed [31:0] x);
      return x < 0 ? 8'd0 : (x > 255 ? 8'd255 : x[7:0]);
   endfunction

   function automatic logic [7:0] clip_px(input logic signed [31:0] a);
      return clamp8(a >>> 16);
   endfunction

   function automatic logic signed [31:0] bias(input logic [7:0] x, input logic signed [31:0] off);
      return $signed({24'd0, x}) - off;
   endfunction

   assign bus.in_ready   = !resetn && state_q == IDLE;
   assign bus.out_valid  = !resetn && state_q inside {OUT0, OUT1, OUT2};
   assign accept         = bus.in_valid && bus.in_ready;
   assign take           = bus.out_valid && bus.out_ready;
   assign last_taken     = take && state_q == OUT2;
   assign frame_end      = last_taken && pair_q == LAST_PAIR;
   assign bus.frame_done = frame_end;

   // Multiplier operand schedule: Y term, then R-V, G-U, G-V, B-U, both pixels in parallel
   always_comb begin
      coef = state_q == C0 ? 32'sd76284 :
             state_q == C1 ? 32'sd104595 :
             state_q == C2 ? 32'sd25624 :
             state_q == C3 ? 32'sd53281 : 32'sd132251;
      op0  = state_q == C0 ? bias(y0_q, 32'sd16) :
             (state_q == C1 || state_q == C3) ? bias(v0_q, 32'sd128) : bias(u0_q, 32'sd128);
      op1  = state_q == C0 ? bias(y1_q, 32'sd16) :
             (state_q == C1 || state_q == C3) ? bias(v1_q, 32'sd128) : bias(u1_q, 32'sd128);
      m0   = coef * op0;
      m1   = coef * op1;
   end

   // Word packing: {R0,G0}, {B0,R1}, {G1,B1}
   always_comb begin
      hi_acc       = state_q == OUT0 ? r0_q : (state_q == OUT1 ? b0_q : g1_q);
      lo_acc       = state_q == OUT0 ? g0_q : (state_q == OUT1 ? r1_q : b1_q);
      bus.out_data = bus.out_valid ? {clip_px(hi_acc), clip_px(lo_acc)} : 16'd0;
   end

   // Next state: five compute cycles, then three words each waiting for out_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.in_valid ? C0 : IDLE;
         C0:      state_d = C1;
         C1:      state_d = C2;
         C2:      state_d = C3;
         C3:      state_d = C4;
         C4:      state_d = OUT0;
         OUT0:    state_d = bus.out_ready ? OUT1 : OUT0;
         OUT1:    state_d = bus.out_ready ? OUT2 : OUT1;
         OUT2:    state_d = bus.out_ready ? IDLE : OUT2;
         default: state_d = IDLE;
      endcase
   end

   // State register and frame pair counter
   always_ff @(posedge CLOCK_50_I) begin
      if (resetn) begin
         state_q <= IDLE;
         pair_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         if (last_taken)
            pair_q <= frame_end ? 16'd0 : pair_q + 16'd1;
      end
   end

   // Operand capture with chroma clamping, and accumulation of the shared products
   always_ff @(posedge CLOCK_50_I) begin
      if (accept) begin
         y0_q <= bus.y_word[15:8];
         y1_q <= bus.y_word[7:0];
         u0_q <= clamp8(bus.u_even);
         v0_q <= clamp8(bus.v_even);
         u1_q <= clamp8(bus.u_odd);
         v1_q <= clamp8(bus.v_odd);
      end
      case (state_q)
         C0: begin
            r0_q <= m0; g0_q <= m0; b0_q <= m0;
            r1_q <= m1; g1_q <= m1; b1_q <= m1;
         end
         C1: begin r0_q <= r0_q + m0; r1_q <= r1_q + m1; end
         C2: begin g0_q <= g0_q - m0; g1_q <= g1_q - m1; end
         C3: begin g0_q <= g0_q - m0; g1_q <= g1_q - m1; end
         C4: begin b0_q <= b0_q + m0; b1_q <= b1_q + m1; end
         default: ;
      endcase
   end

`ifdef CSC_CLIP_CNT_EN
   logic [1:0]  n_clip;
   logic [16:0] clip_sum;
   logic [15:0] clip_q;

   function automatic logic is_clip(input logic signed [31:0] a);
      logic signed [31:0] s;
      s = a >>> 16;
      return s < 0 || s > 255;
   endfunction

   assign n_clip         = {1'b0, is_clip(hi_acc)} + {1'b0, is_clip(lo_acc)};
   assign clip_sum       = {1'b0, clip_q} + {15'd0, n_clip};
   assign bus.clip_count = clip_q;

   // Saturating count of clipped components in each taken word
   always_ff @(posedge CLOCK_50_I) begin
      if (resetn)
         clip_q <= 16'd0;
      else if (take)
         clip_q <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
   end
`else
   assign bus.clip_count = 16'd0;
`endif
endmodule

// File: tb/tb_csc_rgb_pack.sv
// tb_csc_rgb_pack: scoreboard bench for csc_rgb_pack (frame of two pairs)
module tb_csc_rgb_pack;
   localparam int PPF = 2;

   typedef struct {
      logic [15:0] w;
      int          idx;
      int          nc;
   } item_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   item_t q[$];
   int    checks = 0, errors = 0, pc = 0, exp_clip = 0, fd_count = 0;
   bit    mon_en = 1'b0;

   always #5 clk = ~clk;

   csc_rgb_pack_if bus();

   csc_rgb_pack #(.PAIRS_PER_FRAME(PPF)) dut (
      .CLOCK_50_I(clk),
      .resetn    (rst),
      .bus       (bus)
   );

   function automatic int chr(input int x);
      return x < 0 ? 0 : (x > 255 ? 255 : x);
   endfunction

   function automatic logic [7:0] cl(input int x);
      return x < 0 ? 8'd0 : (x > 255 ? 8'd255 : 8'(x));
   endfunction

   function automatic int isc(input int x);
      return (x < 0 || x > 255) ? 1 : 0;
   endfunction

   task automatic rgb(input int y, u, v, output int r, g, b);
      int yt, ut, vt;
      yt = y - 16;
      ut = chr(u) - 128;
      vt = chr(v) - 128;
      r = (76284 * yt + 104595 * vt) >>> 16;
      g = (76284 * yt - 25624 * ut - 53281 * vt) >>> 16;
      b = (76284 * yt + 132251 * ut) >>> 16;
   endtask

   task automatic push_pair(input int ye, yo, ue, ve, uo, vo);
      int r0, g0, b0, r1, g1, b1;
      rgb(ye, ue, ve, r0, g0, b0);
      rgb(yo, uo, vo, r1, g1, b1);
      q.push_back(item_t'{w: {cl(r0), cl(g0)}, idx: 0, nc: isc(r0) + isc(g0)});
      q.push_back(item_t'{w: {cl(b0), cl(r1)}, idx: 1, nc: isc(b0) + isc(r1)});
      q.push_back(item_t'{w: {cl(g1), cl(b1)}, idx: 2, nc: isc(g1) + isc(b1)});
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      item_t it;
      logic  fd_exp;
      if (mon_en) begin
         checks++;
         if (bus.clip_count !== 16'(exp_clip)) begin
            errors++;
            $display("FAIL clip_count got %0d want %0d", bus.clip_count, exp_clip);
         end
         if (bus.frame_done === 1'b1) fd_count++;
         if (rst) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== 16'd0 || bus.frame_done !== 1'b0) begin
               errors++;
               $display("FAIL reset_outputs got v=%b r=%b d=%h fd=%b want 0 0 0000 0",
                        bus.out_valid, bus.in_ready, bus.out_data, bus.frame_done);
            end
            q.delete();
            pc = 0;
            exp_clip = 0;
         end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra_word got %h want none", bus.out_data);
            end else begin
               it = q.pop_front();
               if (bus.out_data !== it.w) begin
                  errors++;
                  $display("FAIL word%0d got %h want %h", it.idx, bus.out_data, it.w);
               end
               fd_exp = (it.idx == 2 && pc == PPF - 1);
               checks++;
               if (bus.frame_done !== fd_exp) begin
                  errors++;
                  $display("FAIL frame_done got %b want %b", bus.frame_done, fd_exp);
               end
               if (it.idx == 2) pc = (pc == PPF - 1) ? 0 : pc + 1;
`ifdef CSC_CLIP_CNT_EN
               exp_clip = (exp_clip + it.nc > 65535) ? 65535 : exp_clip + it.nc;
`endif
            end
         end else begin
            checks++;
            if (bus.frame_done !== 1'b0) begin
               errors++;
               $display("FAIL frame_done_idle got %b want 0", bus.frame_done);
            end
         end
      end
   end

   task automatic send(input int ye, yo, ue, ve, uo, vo);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait got %b want 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.y_word   = {8'(ye), 8'(yo)};
      bus.u_even   = ue;
      bus.v_even   = ve;
      bus.u_odd    = uo;
      bus.v_odd    = vo;
      push_pair(ye, yo, ue, ve, uo, vo);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.y_word = '0;
      bus.u_even = '0; bus.v_even = '0; bus.u_odd = '0; bus.v_odd = '0;
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_black();
      send(16, 16, 128, 128, 128, 128);
      drain();
   endtask

   task automatic test_white_latency();
      int n = 0;
      send(235, 235, 128, 128, 128, 128);
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL latency got %0d want 5", n);
      end
      drain();
   endtask

   task automatic test_clip_high();
      send(235, 235, 128, 255, 128, 128);
      drain();
      send(235, 20, -1000, 1000, 700, -3);
      drain();
   endtask

   task automatic test_stall();
      int n = 0;
      send(16, 16, 128, 128, -5, 200);
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.y_word    = 16'hFFFF;
      bus.u_even    = -7; bus.v_even = 999; bus.u_odd = 3; bus.v_odd = 44;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || q.size() == 0 || bus.out_data !== q[0].w) begin
            errors++;
            $display("FAIL stall_hold got v=%b rdy=%b d=%h want 1 0 %h", bus.out_valid, bus.in_ready,
                     bus.out_data, q.size() != 0 ? q[0].w : 16'hxxxx);
         end
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_end got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++)
         send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 900)) - 300, int'($urandom_range(0, 900)) - 300,
              int'($urandom_range(0, 900)) - 300, int'($urandom_range(0, 900)) - 300);
      drain();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      send(100, 200, 50, 60, 70, 80);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.clip_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid got in_ready=%b clip=%0d want 1 0", bus.in_ready, bus.clip_count);
      end
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_words got %0d want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      fd_count = 0;
      send(120, 60, 90, 170, 200, 30);
      send(40, 250, 255, 0, 10, 240);
      drain();
      @(negedge clk);
      checks++;
      if (fd_count != 1) begin
         errors++;
         $display("FAIL frame_pulses got %0d want 1", fd_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_black();
      test_white_latency();
      test_clip_high();
      test_stall();
      test_random();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/csc_rgb_pack.md
CSC_RGB_PACK -- requirements
Module: csc_rgb_pack

Interface
REQ-001 SHALL have parameter PAIRS_PER_FRAME, default 38400, meaning the number of pixel pairs per frame (320x240/2).
REQ-002 SHALL have ports CLOCK_50_I  input  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-high reset; the name is kept for codebase consistency.
REQ-004 SHALL have port in_valid  input  1  a pixel-pair operand set is present.
REQ-005 SHALL have port in_ready  output  1  the block accepts the operand set this cycle.
REQ-006 SHALL have port y_word  input  16  [15:8]=Y even, [7:0]=Y odd, unsigned.
REQ-007 SHALL have ports u_even, v_even  input  32 each  signed chroma for the even pixel (upsampler even tap).
REQ-008 SHALL have ports u_odd, v_odd  input  32 each  signed chroma for the odd pixel (FIR output).
REQ-009 SHALL have port out_valid  output  1  out_data holds an RGB write word.
REQ-010 SHALL have port out_ready  input  1  the consumer (SRAM write) takes out_data this cycle.
REQ-011 SHALL have port out_data  output  16  packed RGB word.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when the last word of the frame is taken.
REQ-013 SHALL have port clip_count  output  16  the number of saturated RGB components (see Configuration).

Function
REQ-014 SHALL clamp each chroma input to 0..255 on acceptance; negative -> 0, >255 -> 255.
REQ-015 SHALL accept an operand set on a cycle with in_valid=1 and in_ready=1; in_ready is 1 only in state IDLE.
REQ-016 SHALL use states IDLE -> C0..C4 (one cycle each) -> OUT0 -> OUT1 -> OUT2 -> IDLE.
REQ-017 SHALL use exactly two signed 32-bit multipliers, shared across C0..C4 (10 products per pair).
REQ-018 SHALL compute, per pixel, with Yt=Y-16, Ut=U-128, Vt=V-128: R=76284*Yt+104595*Vt; G=76284*Yt-25624*Ut-53281*Vt; B=76284*Yt+132251*Ut.
REQ-019 SHALL perform all arithmetic 32-bit signed, then apply an arithmetic shift right by 16 (truncation), then clip to 0..255.
REQ-020 SHALL present out_data as OUT0={R0,G0}, OUT1={B0,R1}, OUT2={G1,B1}, with the even pixel = 0 and the odd pixel = 1.
REQ-021 SHALL assert out_valid in OUT0..OUT2 only; first out_valid occurs in the 6th cycle after the accepting cycle.
REQ-022 SHALL hold out_data and the state stable while out_valid=1 and out_ready=0; it advances on out_valid&out_ready.
REQ-023 SHALL ignore in_valid outside IDLE; operands latched at acceptance do not change until the return to IDLE.
REQ-024 SHALL use a 16-bit pair counter that increments when OUT2 is taken; at PAIRS_PER_FRAME-1 it pulses frame_done that same cycle and wraps to 0.
REQ-025 SHALL allow in_ready=1 the cycle after OUT2 is taken; with no in_valid, it stays in IDLE indefinitely.

Reset
REQ-026 SHALL, when resetn=1 at a clock edge, enter IDLE, clear the pair counter and clip_count, and drive out_valid=0, out_data=0, frame_done=0, in_ready=0 during reset.
REQ-027 SHALL discard an in-flight pair and any pending output word on reset mid-operation; no word is emitted afterwards.
REQ-028 SHALL drive in_ready=1 in the first cycle after resetn deasserts.

Configuration
REQ-029 SHALL, with macro CSC_CLIP_CNT_EN defined, increment clip_count once per component clipped (low or high) when its word is taken, saturating at 65535.
REQ-030 SHALL, without CSC_CLIP_CNT_EN, tie clip_count to 0 and synthesize no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: y_word=16/16, all chroma=128 -> words 0x0000, 0x0000, 0x0000.
REQ-032 SHALL cover: y_word=235/235, chroma=128 -> R=G=B=254; words 0xFEFE, 0xFEFE, 0xFEFE; clip_count unchanged.
REQ-033 SHALL cover: Y=235, v_even=255, u_even=128 -> R0=255 (clipped); clip_count +1 with CSC_CLIP_CNT_EN, 0 without.
REQ-034 SHALL cover: Y=16, u_odd=-5 (clamped to 0) -> B1=0; out_ready held 0 for 4 cycles during OUT1 -> out_data stable, no extra words.
REQ-035 SHALL cover: PAIRS_PER_FRAME=2, two pairs back-to-back -> frame_done pulses exactly once, on the 6th taken word.
REQ-036 SHALL cover: resetn pulsed during C2 -> no out_valid afterwards, in_ready=1 the next cycle, counters 0.
